// File: rtl/dpr_read_streamer.sv
// dpr_read_streamer
// Read-side sequencer for one port of a dual-port RAM. It takes a (base, len)
// command, issues consecutive read addresses, absorbs the one-cycle registered
// RAM read latency, and presents the words as a valid/ready stream through a
// 4-entry FIFO. A credit check on issued reads keeps the FIFO from overflowing.
module dpr_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam int                    FIFO_DEPTH = 4;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr;       // next address to issue
  logic [ADDR_WIDTH:0]   remaining;  // reads still to issue
  logic                  addr_v;     // a read address is on ram_addr this cycle
  logic                  q_v;        // ram_q carries a requested word this cycle
  logic                  zero_done;  // done pulse for a zero-length command

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            fifo_count;

  logic       accept, issue, push, pop;
  logic [2:0] outstanding;

  assign ram_we    = 1'b0;
  assign out_valid = (fifo_count != 3'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);
  assign push      = q_v;
  assign pop       = out_valid && out_ready;
  // Words buffered plus reads still travelling through the RAM pipeline.
  assign outstanding = fifo_count + 3'(addr_v) + 3'(q_v);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, issue and completion decode.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    done       = zero_done;
    case (state)
      IDLE: begin
        // The first read is issued on the accepting edge, so ram_addr shows
        // base_addr in the very next cycle.
        if (start && (len != REM_ZERO)) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (remaining == REM_ZERO) begin
          state_next = DRAIN;
        end else if (outstanding < 3'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (remaining == REM_ONE) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((fifo_count == 3'd0) && !addr_v && !q_v) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address generator, read pipeline tracking and zero-length done.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      addr      <= '0;
      remaining <= '0;
      addr_v    <= 1'b0;
      q_v       <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= (state == IDLE) && start && (len == REM_ZERO);
      addr_v    <= accept || issue;
      q_v       <= addr_v;
      if (accept) begin
        ram_addr  <= base_addr;
        addr      <= base_addr + ADDR_ONE;
        remaining <= len - REM_ONE;
      end else if (issue) begin
        ram_addr  <= addr;
        addr      <= addr + ADDR_ONE;
        remaining <= remaining - REM_ONE;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count gates out_valid and out_data, so
    // stale entries are never visible.
    if (push) fifo_mem[wr_ptr] <= ram_q;
  end

endmodule

// File: tb/tb_dpr_read_streamer.sv
// Directed bench for dpr_read_streamer with a registered-read RAM model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_dpr_read_streamer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] len;
  logic       busy, done;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] ram [256];

  int checks = 0;
  int errors = 0;

  dpr_read_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Registered-read RAM port.
  always @(posedge clk) ram_q <= ram[ram_addr];

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, out_valid, ram_we} !== 4'b0000 || ram_addr !== 8'h00 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b valid=%b we=%b addr=%h data=%h, want all 0",
               busy, done, out_valid, ram_we, ram_addr, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Exact cycle timing of a 4-word command with the sink always ready.
  task automatic test_timing();
    logic [7:0] exp_data;
    base_addr = 8'h10; len = 9'd4; start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== (k <= 7)) begin
        errors++; $display("FAIL timing_busy T+%0d: got %b want %b", k, busy, (k <= 7));
      end
      checks++;
      if (done !== (k == 7)) begin
        errors++; $display("FAIL timing_done T+%0d: got %b want %b", k, done, (k == 7));
      end
      checks++;
      if (out_valid !== (k >= 3 && k <= 6)) begin
        errors++; $display("FAIL timing_valid T+%0d: got %b want %b", k, out_valid, (k >= 3 && k <= 6));
      end
      if (k <= 4) begin
        checks++;
        if (ram_addr !== 8'(8'h10 + k - 1)) begin
          errors++; $display("FAIL timing_addr T+%0d: got %h want %h", k, ram_addr, 8'(8'h10 + k - 1));
        end
      end
      if (k >= 3 && k <= 6) begin
        exp_data = 8'(8'hA0 + k - 3);
        checks++;
        if (out_data !== exp_data) begin
          errors++; $display("FAIL timing_data T+%0d: got %h want %h", k, out_data, exp_data);
        end
      end
    end
  endtask

  // Run one command. mode 0: always ready; 1: random ready; 2: ready low T..T+12.
  task automatic run_stream(input logic [7:0] b, input int n, input int mode, input string tag);
    int k = 0, beats = 0, dones = 0, gaps = 0, we_bad = 0;
    logic hold = 1'b0;
    logic [7:0] hold_data = '0, exp;
    base_addr = b; len = 9'(n); start = 1'b1; out_ready = (mode == 0);
    while (k < 3000) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k >= 13);
      endcase
      if (ram_we !== 1'b0) we_bad++;
      if (done === 1'b1) dones++;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_data) begin
          errors++;
          $display("FAIL %s_stable k=%0d: valid=%b data=%h want 1/%h", tag, k, out_valid, out_data, hold_data);
        end
      end
      if (mode == 0 && k <= n && k <= 8) begin
        checks++;
        if (ram_addr !== 8'(b + k - 1)) begin
          errors++; $display("FAIL %s_addr k=%0d: got %h want %h", tag, k, ram_addr, 8'(b + k - 1));
        end
      end
      if (mode == 2 && (k == 6 || k == 12)) begin
        checks++;
        if (ram_addr !== 8'(b + 3)) begin
          errors++; $display("FAIL %s_stall_addr k=%0d: got %h want %h", tag, k, ram_addr, 8'(b + 3));
        end
      end
      if (mode == 2 && beats > 0 && beats < n && out_valid !== 1'b1) gaps++;
      if (out_valid === 1'b1 && out_ready) begin
        exp = ram[8'(b + beats)];
        checks++;
        if (out_data !== exp) begin
          errors++; $display("FAIL %s_data beat=%0d: got %h want %h", tag, beats, out_data, exp);
        end
        beats++;
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      if (dones > 0 && busy === 1'b0) break;
    end
    out_ready = 1'b0;
    checks++;
    if (beats != n || dones != 1 || k >= 3000) begin
      errors++; $display("FAIL %s_count: beats=%0d dones=%0d cycles=%0d want beats=%0d dones=1", tag, beats, dones, k, n);
    end
    checks++;
    if (we_bad != 0 || gaps != 0) begin
      errors++; $display("FAIL %s_we_gaps: we_high=%0d gaps=%0d want 0/0", tag, we_bad, gaps);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    run_stream(8'hFE, 4, 0, "wrap");
  endtask

  task automatic test_backpressure();
    run_stream(8'h40, 16, 2, "bp");
  endtask

  task automatic test_random_ready();
    run_stream(8'h00, 256, 1, "rand");
  endtask

  task automatic test_zero_len();
    int vseen = 0;
    base_addr = 8'h55; len = 9'd0; start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid !== 1'b0) vseen++;
      checks++;
      if (done !== (k == 1) || busy !== 1'b0) begin
        errors++; $display("FAIL zero_len T+%0d: done=%b busy=%b want %b/0", k, done, busy, (k == 1));
      end
    end
    checks++;
    if (vseen != 0) begin
      errors++; $display("FAIL zero_len_valid: valid cycles=%0d want 0", vseen);
    end
  endtask

  // A start during a command must not disturb it.
  task automatic test_start_ignored();
    int beats = 0, dones = 0;
    base_addr = 8'h30; len = 9'd3; start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = (k == 2);
      if (k == 2) begin base_addr = 8'h80; len = 9'd5; end
      if (done === 1'b1) dones++;
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== ram[8'(8'h30 + beats)]) begin
          errors++; $display("FAIL ignore_data beat=%0d: got %h want %h", beats, out_data, ram[8'(8'h30 + beats)]);
        end
        beats++;
      end
    end
    checks++;
    if (beats != 3 || dones != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_count: beats=%0d dones=%0d busy=%b want 3/1/0", beats, dones, busy);
    end
  endtask

  task automatic test_mid_reset();
    base_addr = 8'h60; len = 9'd8; start = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (k == 5);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || ram_addr !== 8'h00 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b done=%b addr=%h data=%h want 0", busy, out_valid, done, ram_addr, out_data);
    end
    @(negedge clk);
    run_stream(8'h00, 2, 0, "post_rst");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 4; i++) ram[8'h10 + i] = 8'(8'hA0 + i);
    test_reset();
    test_timing();
    test_wrap();
    test_backpressure();
    test_random_ready();
    test_zero_len();
    test_start_ignored();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
